// File: rtl/gfx_fb_fill_pkg.sv
// rtl/gfx_fb_fill_pkg.sv - shared state encoding and AXI constants for the framebuffer fill engine
package gfx_fb_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } fill_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/gfx_fb_fill.sv
// rtl/gfx_fb_fill.sv - AXI write master that fills a framebuffer region with a constant word
module gfx_fb_fill
    import gfx_fb_fill_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 21,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int H_WIDTH        = 12,
    parameter int V_WIDTH        = 12,
    parameter int BURST_LEN      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          continuous,
    input  logic [AXI_ADDR_WIDTH-1:0]     base_addr,
    input  logic [H_WIDTH-1:0]            h_visible,
    input  logic [V_WIDTH-1:0]            v_visible,
    input  logic [AXI_DATA_WIDTH-1:0]     fill_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                    m_axi_bresp
);

    localparam int BYTES     = AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int CW        = H_WIDTH + V_WIDTH;
    localparam logic [CW-1:0] BURST_WORDS = CW'(BURST_LEN);

    fill_state_t state, state_n;

    logic                      cont_q;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic [AXI_DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]             total_in, total_q, sent_q, remaining_q, burst_words;
    logic [7:0]                len_q, beat_q, awlen_c;
    logic                      done_q, err_q;
    logic                      start_ok, aw_fire, w_fire, b_fire, last_burst;
    logic                      unused_bid;

    assign total_in    = CW'(h_visible) * CW'(v_visible);
    assign start_ok    = start && (state == ST_IDLE);
    assign aw_fire     = m_axi_awvalid && m_axi_awready;
    assign w_fire      = m_axi_wvalid && m_axi_wready;
    assign b_fire      = m_axi_bvalid && m_axi_bready;
    assign awlen_c     = (remaining_q >= BURST_WORDS) ? 8'(BURST_LEN - 1) : 8'(remaining_q - CW'(1));
    assign burst_words = CW'(len_q) + CW'(1);
    assign last_burst  = (remaining_q == burst_words);
    assign unused_bid  = ^m_axi_bid;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start && total_in != '0) state_n = ST_ADDR;
            ST_ADDR: if (aw_fire) state_n = ST_DATA;
            ST_DATA: if (w_fire && m_axi_wlast) state_n = ST_RESP;
            // A continuous fill loops straight back to ADDR with the counters reloaded.
            ST_RESP: if (b_fire) state_n = (!last_burst || cont_q) ? ST_ADDR : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_q      <= 1'b0;
            base_q      <= '0;
            data_q      <= '0;
            total_q     <= '0;
            sent_q      <= '0;
            remaining_q <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_ok) begin
                cont_q      <= continuous;
                base_q      <= base_addr;
                data_q      <= fill_data;
                total_q     <= total_in;
                remaining_q <= total_in;
                sent_q      <= '0;
                beat_q      <= '0;
                err_q       <= 1'b0;
                if (total_in == '0) done_q <= 1'b1;
            end
            if (aw_fire) len_q <= awlen_c;
            if (w_fire)  beat_q <= m_axi_wlast ? 8'd0 : beat_q + 8'd1;
            if (b_fire) begin
                if (m_axi_bresp != RESP_OKAY) err_q <= 1'b1;
                if (last_burst) begin
                    done_q      <= 1'b1;
                    sent_q      <= '0;
                    remaining_q <= cont_q ? total_q : '0;
                end else begin
                    sent_q      <= sent_q + burst_words;
                    remaining_q <= remaining_q - burst_words;
                end
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_awvalid = (state == ST_ADDR);
    assign m_axi_awaddr  = base_q + AXI_ADDR_WIDTH'(sent_q << SIZE_LOG2);
    assign m_axi_awid    = '0;
    assign m_axi_awlen   = awlen_c;
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_wvalid  = (state == ST_DATA);
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state == ST_DATA) && (beat_q == len_q);
    assign m_axi_bready  = (state == ST_RESP);

endmodule

// File: doc/gfx_fb_fill.md
GFX_FB_FILL -- requirements
Module: gfx_fb_fill

Interface
REQ-001 Parameters (name, default, meaning): AXI_ADDR_WIDTH, 21, byte address width; AXI_DATA_WIDTH, 16, beat width; AXI_ID_WIDTH, 4, ID width; H_WIDTH, 12, width field; V_WIDTH, 12, height field; BURST_LEN, 16, max beats per burst (power of two, 1..256).
REQ-002 Clocking: one clock, clk; reset rst, synchronous, active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, sync active-high reset
- start, in, 1, begin fill when idle
- continuous, in, 1, restart automatically after each completed fill
- base_addr, in, AXI_ADDR_WIDTH, byte address of pixel (0,0)
- h_visible, in, H_WIDTH, pixels per line
- v_visible, in, V_WIDTH, lines
- fill_data, in, AXI_DATA_WIDTH, word written to every pixel
- busy, out, 1, fill in progress
- done, out, 1, one-cycle completion pulse
- err, out, 1, sticky: non-OKAY bresp seen
- m_axi_awvalid/awready, out/in, 1, write address handshake
- m_axi_awaddr, out, AXI_ADDR_WIDTH, burst start address
- m_axi_awid, out, AXI_ID_WIDTH, constant 0
- m_axi_awlen, out, 8, beats-1
- m_axi_awsize, out, 3, log2(AXI_DATA_WIDTH/8)
- m_axi_awburst, out, 2, constant INCR (01)
- m_axi_wvalid/wready, out/in, 1, write data handshake
- m_axi_wdata, out, AXI_DATA_WIDTH, fill_data
- m_axi_wstrb, out, AXI_DATA_WIDTH/8, all ones
- m_axi_wlast, out, 1, final beat of burst
- m_axi_bvalid/bready, in/out, 1, response handshake
- m_axi_bid, in, AXI_ID_WIDTH, ignored
- m_axi_bresp, in, 2, response code

Function
REQ-004 Total words N = h_visible*v_visible; start, continuous, base_addr, h_visible, v_visible, fill_data captured on accepted start and held for the whole fill.
REQ-005 FSM states IDLE, ADDR, DATA, RESP; IDLE->ADDR on start (N>0); ADDR->DATA on awvalid&&awready; DATA->RESP on wvalid&&wready&&wlast; RESP->ADDR if words remain, else ->IDLE with done=1 for one cycle.
REQ-006 Burst k: awaddr = base + words_sent*(AXI_DATA_WIDTH/8); awlen = min(BURST_LEN, remaining)-1; base_addr is BURST_LEN*bytes aligned, so no burst crosses a 4KB boundary.
REQ-007 Exactly one burst outstanding; awvalid only in ADDR, wvalid only in DATA, bready=1 only in RESP; valids held until handshake and never dropped.
REQ-008 wlast asserted only on beat awlen; beat counter wraps to 0 per burst.
REQ-009 Remaining-word counter width H_WIDTH+V_WIDTH; no overflow at max dimensions.
REQ-010 start with N==0: no AXI traffic, done pulses the next cycle, busy stays 0.
REQ-011 start while busy ignored.
REQ-012 Captured continuous=1: on completion, done pulses and the next fill starts the following cycle from base_addr with the same captured values; cleared only by reset.
REQ-013 bresp!=OKAY sets err; fill still runs to completion; err clears on next accepted start.
REQ-014 busy=1 in ADDR/DATA/RESP.

Reset
REQ-015 On rst: state IDLE; busy, done, err, awvalid, wvalid, bready = 0; counters 0; other outputs constant-driven.
REQ-016 Reset mid-burst abandons the transaction immediately; the slave is reset in the same domain.

Structure
REQ-017 Package gfx_fb_fill_pkg holds the state enum and AXI constants (BURST_INCR, RESP_OKAY).
REQ-018 Flat module; no sub-module required.

Verification
REQ-019 h=4,v=2,BURST_LEN=16,base=0 -> one burst, awaddr=0, awlen=7, 8 beats, wlast on beat 7, one done pulse.
REQ-020 h=20,v=1,base=0x100 -> awaddr 0x100 awlen 15, then awaddr 0x120 awlen 3; done after second B.
REQ-021 Random awready/wready/bvalid stalls on 640x480 fill -> exactly 307200 beats, no valid drop, data unchanged.
REQ-022 bresp=SLVERR on burst 2 -> err=1 sticky, all bursts still issued; new start clears err.
REQ-023 h=0 -> no awvalid, done one cycle after start; continuous=1,h=2,v=2 -> back-to-back fills, done each 4 beats.
REQ-024 rst asserted during DATA -> next cycle all valids 0, busy 0; later start runs a clean fill.
